// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width: enough to hold values 0..w
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_div_sub.sv
// WIDTH+1-bit subtractor for the restoring divider: full_adder ripple chain
// computing a + ~b + 1, with borrow taken as the inverted final carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module seq_div_sub #(
  parameter int N = 11
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  logic [N:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_rca
    full_adder u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (c[i]),
      .s  (diff[i]),
      .co (c[i+1])
    );
  end

  assign borrow = ~c[N];
endmodule

// File: rtl/seq_restoring_div.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Optional macro SEQ_DIV_ZERO_DETECT_EN: divisor==0 skips straight to DONE and flags div_by_zero.
module seq_restoring_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   kept;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] acc_nx;
  logic             accept;
  logic             last;
  logic             zero_exit;
  logic             unused_top;

  // acc starts as the dividend and shifts left; freed LSBs collect quotient bits
  assign shifted = {rem, acc[WIDTH-1]};

  seq_div_sub #(.N(WIDTH + 1)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign kept       = borrow ? shifted : diff;
  assign rem_nx     = kept[WIDTH-1:0];
  assign unused_top = kept[WIDTH];
  assign acc_nx     = {acc[WIDTH-2:0], ~borrow};

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_DIV_ZERO_DETECT_EN
  assign zero_exit = accept && (divisor == '0);
`else
  assign zero_exit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = zero_exit ? DONE : RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= '0;
        if (zero_exit) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        if (last) begin
          quotient  <= acc_nx;
          remainder <= rem_nx;
        end
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      acc <= dividend;
      dvs <= divisor;
      rem <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      rem <= rem_nx;
    end
  end

`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic dbz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dbz_q <= 1'b0;
    end else if (zero_exit) begin
      dbz_q <= 1'b1;
    end else if (state == RUN && last) begin
      dbz_q <= 1'b0;
    end
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_restoring_div.sv
// Bench for seq_restoring_div (WIDTH=10): vector table, hand-written corner sequences, random ops vs. arithmetic model.
module tb_seq_restoring_div;

  localparam int W = 10;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_restoring_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: plain integer division; zero divisor yields all-ones / dividend
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int z, output int lat);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      z = 1;
      lat = 1;
`else
      z = 0;
      lat = W + 1;
`endif
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
      lat = W + 1;
    end
  endfunction

  // Issue one operation; lat = cycle index (accept cycle = 0) where done is seen, -1 if never
  task automatic do_op(input int a, input int b, output int lat, output int q,
                       output int r, output int z, output int busy_bad);
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = -1; q = 0; r = 0; z = 0; busy_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        lat = n;
        q = int'(quotient);
        r = int'(remainder);
        z = int'(div_by_zero);
        break;
      end
    end
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0) busy_bad++;
  endtask

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, q, r, z, bb, eq, er, ez, elat, ndone, dq, dr, dlat;
    int zl;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    rst = 1'b0;

`ifdef SEQ_DIV_ZERO_DETECT_EN
    zl = 1;
`else
    zl = 11;
`endif
    vecs.push_back('{1000, 7, 142, 6, 11});
    vecs.push_back('{1023, 1, 1023, 0, 11});
    vecs.push_back('{5, 9, 0, 5, 11});
    vecs.push_back('{81, 9, 9, 0, 11});
    vecs.push_back('{0, 5, 0, 0, 11});
    vecs.push_back('{1023, 1023, 1, 0, 11});
    vecs.push_back('{1, 1023, 0, 1, 11});
    vecs.push_back('{1022, 512, 1, 510, 11});
    vecs.push_back('{100, 0, 1023, 100, zl});

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat, q, r, z, bb);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d_busy_window", i), bb, 0);
`ifdef SEQ_DIV_ZERO_DETECT_EN
      check($sformatf("vec%0d_dbz", i), z, (vecs[i].b == 0) ? 1 : 0);
`else
      check($sformatf("vec%0d_dbz", i), z, 0);
`endif
    end

    // Held results must persist after done
    repeat (3) @(negedge clk);
    check("hold_quotient", int'(quotient), 1023);
    check("hold_remainder", int'(remainder), 100);

    // Start while RUN and during DONE must be ignored
    @(negedge clk);
    dividend = 10'd1000; divisor = 10'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; dq = 0; dr = 0; dlat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (dlat < 0) begin
          dlat = n; dq = int'(quotient); dr = int'(remainder);
        end
      end
      if (n == 12) check("ignore_idle_after_done", int'(busy), 0);
      start    = (n == 4 || n == 11);
      dividend = 10'd50;
      divisor  = 10'd5;
    end
    start = 1'b0;
    check("ignore_done_count", ndone, 1);
    check("ignore_latency", dlat, 11);
    check("ignore_quotient", dq, 142);
    check("ignore_remainder", dr, 6);

    // Reset mid-operation aborts with no done pulse
    @(negedge clk);
    dividend = 10'd1000; divisor = 10'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 5; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_dbz", int'(div_by_zero), 0);
    // rst wins over start in the same cycle
    start = 1'b1; dividend = 10'd81; divisor = 10'd9;
    @(negedge clk);
    check("rst_over_start_busy", int'(busy), 0);
    start = 1'b0; rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);
    do_op(81, 9, lat, q, r, z, bb);
    check("after_abort_latency", lat, 11);
    check("after_abort_quotient", q, 9);
    check("after_abort_remainder", r, 0);

    // Random operations against the arithmetic model
    for (int k = 0; k < 200; k++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << W) - 1));
      b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
      model(a, b, eq, er, ez, elat);
      do_op(a, b, lat, q, r, z, bb);
      check($sformatf("rand%0d_q(%0d/%0d)", k, a, b), q, eq);
      check($sformatf("rand%0d_r(%0d/%0d)", k, a, b), r, er);
      check($sformatf("rand%0d_lat", k), lat, elat);
      check($sformatf("rand%0d_dbz", k), z, ez);
      check($sformatf("rand%0d_busy", k), bb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_restoring_div.md
SEQ_RESTORING_DIV -- requirements
Module: seq_restoring_div

Interface
REQ-001 SHALL have parameter WIDTH, default 10, operand/result bit width (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend, captured on accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high in RUN and DONE.
REQ-008 SHALL have port done  output  1  single-cycle pulse, results valid.
REQ-009 SHALL have port quotient  output  WIDTH  unsigned quotient.
REQ-010 SHALL have port remainder  output  WIDTH  unsigned remainder.
REQ-011 SHALL have port div_by_zero  output  1  divisor-zero flag (see Configuration).

Function
REQ-012 SHALL implement an unsigned restoring divider, one quotient bit per cycle, MSB first.
REQ-013 SHALL use states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after WIDTH iterations, DONE->IDLE unconditionally next cycle.
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored with no effect on the operation in flight.
REQ-015 SHALL capture dividend and divisor in the accepting cycle; later input changes SHALL NOT affect the result.
REQ-016 Each RUN iteration SHALL shift {partial remainder, next dividend bit} left, subtract divisor over WIDTH+1 bits, keep the difference and set quotient bit 1 if no borrow, else restore and set bit 0.
REQ-017 SHALL use a $clog2(WIDTH+1)-bit iteration counter, cleared on accept, terminal at WIDTH-1.
REQ-018 done SHALL assert exactly WIDTH+1 cycles after the start-accept edge and last one cycle (DONE state).
REQ-019 quotient, remainder and div_by_zero SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-020 A start sampled in the DONE cycle SHALL be ignored; back-to-back throughput is one operation per WIDTH+2 cycles.
REQ-021 Results SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for divisor != 0.

Reset
REQ-022 rst SHALL force IDLE and drive busy=0, done=0, quotient=0, remainder=0, div_by_zero=0 on the next edge.
REQ-023 rst mid-operation SHALL abort it with no done pulse; rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 Macro SEQ_DIV_ZERO_DETECT_EN SHALL control divisor-zero early exit.
REQ-025 With it defined: divisor==0 at accept SHALL go IDLE->DONE directly (done 1 cycle after accept), quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1.
REQ-026 Without it: divisor==0 SHALL run the full WIDTH iterations, yielding quotient={WIDTH{1}}, remainder=dividend at normal latency; div_by_zero SHALL be tied 0.

Structure
REQ-027 Package seq_div_pkg SHALL hold the state enum (IDLE, RUN, DONE) and a counter-width function of WIDTH.
REQ-028 The WIDTH+1-bit subtract SHALL be a sub-module seq_div_sub built as a full_adder ripple chain with inverted divisor and carry-in 1, borrow = NOT carry-out.

Verification (WIDTH=10)
REQ-029 start, 1000/7 -> done at accept+11, quotient=142, remainder=6, busy high cycles 1..11.
REQ-030 1023/1 -> quotient=1023, remainder=0; 5/9 -> quotient=0, remainder=5.
REQ-031 100/0 -> with macro: done at accept+1, quotient=1023, remainder=100, div_by_zero=1; without: done at accept+11, same values, div_by_zero=0.
REQ-032 start 1000/7, then start 50/5 at accept+4 and at DONE cycle -> both ignored, result 142/6, no second done.
REQ-033 rst at accept+5 -> no done, all outputs 0 next cycle; subsequent start 81/9 -> quotient=9, remainder=0.
